instr_fetch_queue: RTL



---
 rtl/instr_fetch_queue.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues two-byte instructions from a byte-wide synchronous ROM,
// assembles them into a FIFO and owns the fetch PC. FETCH_STATS_EN adds pop/redirect counters.
module instr_fetch_queue #(
  parameter int unsigned IQ_DEPTH = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_en,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode1,
  output logic [7:0]  opcode2,
  output logic [7:0]  instr_pc,
  input  logic        jump_taken,
  input  logic [7:0]  jump_target,
  output logic [7:0]  fetch_pc,
  output logic [15:0] instr_count,
  output logic [15:0] flush_count
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_OP1, S_OP2} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  logic [CNT_W:0]   occupancy;
  logic             slot_free;
  logic             push;
  logic             pop;

  logic             op2_p0;
  logic             vld_p1;
  logic             op2_p1;
  logic             kill_p1;
  logic [7:0]       addr_p1;
  logic [7:0]       op1_hold_p2;
  logic [7:0]       pc_hold_p2;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       fifo_op1 [IQ_DEPTH];
  logic [7:0]       fifo_op2 [IQ_DEPTH];
  logic [7:0]       fifo_pc  [IQ_DEPTH];

  // pending counts instructions whose opcode1 is issued but not yet pushed;
  // up to two may overlap, so it is a counter rather than a flag.
  assign occupancy = {1'b0, count} + {1'b0, pending};
  assign slot_free = (occupancy < (CNT_W+1)'(IQ_DEPTH));
  assign push      = vld_p1 & op2_p1 & ~kill_p1;
  assign pop       = instr_valid & instr_ready;

  // ---- p0: issue FSM and fetch PC ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_OP1;
      fetch_pc <= RESET_PC;
      rom_en   <= 1'b0;
      rom_addr <= 8'h00;
      op2_p0   <= 1'b0;
      pending  <= '0;
    end else if (jump_taken) begin
      // The flushed queue always passes the slot check, so the target's
      // opcode1 is issued straight away.
      state    <= S_OP2;
      fetch_pc <= jump_target;
      rom_en   <= 1'b1;
      rom_addr <= jump_target;
      op2_p0   <= 1'b0;
      pending  <= CNT_W'(1);
    end else begin
      case (state)
        S_OP1: begin
          op2_p0 <= 1'b0;
          if (slot_free) begin
            rom_en   <= 1'b1;
            rom_addr <= fetch_pc;
            pending  <= pending + CNT_W'(1) - CNT_W'(push);
            state    <= S_OP2;
          end else begin
            rom_en  <= 1'b0;
            pending <= pending - CNT_W'(push);
          end
        end
        S_OP2: begin
          rom_en   <= 1'b1;
          rom_addr <= fetch_pc + 8'd1;
          op2_p0   <= 1'b1;
          fetch_pc <= fetch_pc + 8'd2;
          pending  <= pending - CNT_W'(push);
          state    <= S_OP1;
        end
        default: begin
          rom_en <= 1'b0;
          op2_p0 <= 1'b0;
          state  <= S_OP1;
        end
      endcase
    end
  end

  // ---- p1/p2: ROM return alignment and opcode1 hold ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      op2_p1      <= 1'b0;
      kill_p1     <= 1'b0;
      addr_p1     <= 8'h00;
      op1_hold_p2 <= 8'h00;
      pc_hold_p2  <= 8'h00;
    end else begin
      vld_p1  <= rom_en;
      op2_p1  <= op2_p0;
      addr_p1 <= rom_addr;
      kill_p1 <= jump_taken;
      if (vld_p1 && !op2_p1 && !kill_p1) begin
        op1_hold_p2 <= rom_data;
        pc_hold_p2  <= addr_p1;
      end
    end
  end

  // ---- instruction FIFO ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        fifo_op1[i] <= 8'h00;
        fifo_op2[i] <= 8'h00;
        fifo_pc[i]  <= 8'h00;
      end
    end else if (jump_taken) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_op1[wr_ptr] <= op1_hold_p2;
        fifo_op2[wr_ptr] <= rom_data;
        fifo_pc[wr_ptr]  <= pc_hold_p2;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign instr_valid = (count != '0);
  assign opcode1     = fifo_op1[rd_ptr];
  assign opcode2     = fifo_op2[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

`ifdef FETCH_STATS_EN
  logic [15:0] instr_cnt_r;
  logic [15:0] flush_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (pop)        instr_cnt_r <= sat_inc(instr_cnt_r);
      if (jump_taken) flush_cnt_r <= sat_inc(flush_cnt_r);
    end
  end

  assign instr_count = instr_cnt_r;
  assign flush_count = flush_cnt_r;
`else
  assign instr_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule
